mem_port_arbiter: RTL

Two-requester arbiter and sequencer for a single shared memory port in the RISC-V core, typically instruction fetch (requester 1) and load/store unit (requester 2). It selects one requester with round-robin fairness and holds the grant until the memory acknowledges or a watchdog expires. It drives the `sel` line of the parallel data multiplexers that steer address, write data and write enable onto the port, and returns the read data with a one-cycle completion pulse.

---
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for two requesters sharing one memory port.
// Holds the grant until the memory acks or the watchdog fires, then returns a one-cycle completion pulse.
module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int AWIDTH  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r1_req,
  input  logic [AWIDTH-1:0] r1_addr,
  input  logic [WIDTH-1:0]  r1_wdata,
  input  logic              r1_we,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [WIDTH-1:0]  r1_rdata,
  output logic              r1_err,
  input  logic              r2_req,
  input  logic [AWIDTH-1:0] r2_addr,
  input  logic [WIDTH-1:0]  r2_wdata,
  input  logic              r2_we,
  output logic              r2_gnt,
  output logic              r2_rvalid,
  output logic [WIDTH-1:0]  r2_rdata,
  output logic              r2_err,
  output logic              sel,
  output logic              mem_req,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              mem_we,
  input  logic              mem_ack,
  input  logic [WIDTH-1:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // The counter only needs to reach TIMEOUT-1: the cycle holding that value is the last BUSY cycle.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state_reg;
  logic            sel_reg;
  logic            pri_reg;
  logic [CW-1:0]   cnt_reg;
  logic [1:0]      rvalid_reg;
  logic [1:0]      err_reg;
  logic [WIDTH-1:0] rdata_reg [2];

  logic busy;
  logic timeout;
  logic finish;

  assign busy    = (state_reg == BUSY);
  assign timeout = (TIMEOUT != 0) && (cnt_reg == LAST);
  assign finish  = busy && (mem_ack || timeout);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= 1'b0;
      pri_reg   <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (r1_req && (!r2_req || pri_reg)) begin
            sel_reg   <= 1'b1;
            state_reg <= BUSY;
          end else if (r2_req) begin
            sel_reg   <= 1'b0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (TIMEOUT != 0) cnt_reg <= cnt_reg + CW'(1);
          if (mem_ack || timeout) state_reg <= DONE;
        end
        DONE: begin
          pri_reg   <= !sel_reg;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Completion registers per requester; index 0 is requester 1 (sel=1), index 1 is requester 2.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cpl
      logic own;
      assign own = (gi == 0) ? sel_reg : !sel_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          rvalid_reg[gi] <= 1'b0;
          err_reg[gi]    <= 1'b0;
          rdata_reg[gi]  <= '0;
        end else begin
          rvalid_reg[gi] <= 1'b0;
          if (finish && own) begin
            rvalid_reg[gi] <= 1'b1;
            err_reg[gi]    <= !mem_ack;
            rdata_reg[gi]  <= mem_ack ? mem_rdata : '0;
          end
        end
      end
    end
  endgenerate

  assign sel       = sel_reg;
  assign mem_req   = busy;
  assign r1_gnt    = busy && sel_reg;
  assign r2_gnt    = busy && !sel_reg;
  assign mem_addr  = sel_reg ? r1_addr  : r2_addr;
  assign mem_wdata = sel_reg ? r1_wdata : r2_wdata;
  assign mem_we    = sel_reg ? r1_we    : r2_we;

  assign r1_rvalid = rvalid_reg[0];
  assign r2_rvalid = rvalid_reg[1];
  assign r1_err    = err_reg[0];
  assign r2_err    = err_reg[1];
  assign r1_rdata  = rdata_reg[0];
  assign r2_rdata  = rdata_reg[1];

endmodule
